// File: rtl/load_store_unit.sv
// Load/store unit: splits misaligned accesses into byte beats (or rejects them) and extends load data.
// Latency: aligned accept+2, split accept+N+1, error accept+1; accepts only in IDLE, response is never backpressured.
module load_store_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        split_q, split_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_misaligned_q, resp_misaligned_d;
  logic        resp_error_q, resp_error_d;

  logic        req_aligned;
  logic        req_illegal;
  logic [1:0]  last_beat;
  logic [31:0] wshift;
  logic [31:0] load_ext;

  assign req_ready = (state_q == IDLE);
  assign req_aligned = (req_size == 2'b00) ||
                       (req_size == 2'b01 && !req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] == 2'b00);
  assign req_illegal = (req_size == 2'b11) || (!req_aligned && !SPLIT_MISALIGNED);
  assign last_beat   = (size_q == 2'b01) ? 2'd1 : 2'd3;

  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    write_d           = write_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    size_d            = size_q;
    uns_d             = uns_q;
    split_d           = split_q;
    asm_d             = asm_q;
    mem_address_d     = mem_address_q;
    mem_write_data_d  = mem_write_data_q;
    mem_write_d       = mem_write_q;
    mem_read_d        = mem_read_q;
    mem_size_d        = mem_size_q;
    resp_valid_d      = resp_valid_q;
    resp_rdata_d      = resp_rdata_q;
    resp_misaligned_d = resp_misaligned_q;
    resp_error_d      = resp_error_q;
    wshift            = 32'd0;
    load_ext          = 32'd0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          beat_d  = 2'd0;
          asm_d   = 32'd0;
          if (req_illegal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d          = ACCESS;
            split_d          = !req_aligned;
            mem_address_d    = req_addr;
            mem_size_d       = req_aligned ? req_size : 2'b00;
            mem_write_data_d = req_aligned ? req_wdata : {24'd0, req_wdata[7:0]};
            mem_write_d      = req_write;
            mem_read_d       = !req_write;
          end
        end
      end
      ACCESS: begin
        if (!write_q) begin
          if (split_q) asm_d[{beat_q, 3'b000} +: 8] = mem_read_data[7:0];
          else         asm_d = mem_read_data;
        end
        // Extension is always redone here; upper bits returned by memory for narrow reads are ignored.
        case (size_q)
          2'b00:   load_ext = uns_q ? {24'd0, asm_d[7:0]}  : {{24{asm_d[7]}}, asm_d[7:0]};
          2'b01:   load_ext = uns_q ? {16'd0, asm_d[15:0]} : {{16{asm_d[15]}}, asm_d[15:0]};
          default: load_ext = asm_d;
        endcase
        if (!split_q || beat_q == last_beat) begin
          state_d           = RESP;
          mem_write_d       = 1'b0;
          mem_read_d        = 1'b0;
          resp_valid_d      = 1'b1;
          resp_misaligned_d = split_q;
          resp_rdata_d      = write_q ? 32'd0 : load_ext;
        end else begin
          beat_d           = beat_q + 2'd1;
          mem_address_d    = addr_q + {30'd0, beat_d};
          wshift           = wdata_q >> {beat_d, 3'b000};
          mem_write_data_d = {24'd0, wshift[7:0]};
        end
      end
      RESP: begin
        state_d           = IDLE;
        resp_valid_d      = 1'b0;
        resp_misaligned_d = 1'b0;
        resp_error_d      = 1'b0;
        resp_rdata_d      = 32'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      beat_q            <= 2'd0;
      write_q           <= 1'b0;
      addr_q            <= 32'd0;
      wdata_q           <= 32'd0;
      size_q            <= 2'b00;
      uns_q             <= 1'b0;
      split_q           <= 1'b0;
      asm_q             <= 32'd0;
      mem_address_q     <= 32'd0;
      mem_write_data_q  <= 32'd0;
      mem_write_q       <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_size_q        <= 2'b00;
      resp_valid_q      <= 1'b0;
      resp_rdata_q      <= 32'd0;
      resp_misaligned_q <= 1'b0;
      resp_error_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      beat_q            <= beat_d;
      write_q           <= write_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      size_q            <= size_d;
      uns_q             <= uns_d;
      split_q           <= split_d;
      asm_q             <= asm_d;
      mem_address_q     <= mem_address_d;
      mem_write_data_q  <= mem_write_data_d;
      mem_write_q       <= mem_write_d;
      mem_read_q        <= mem_read_d;
      mem_size_q        <= mem_size_d;
      resp_valid_q      <= resp_valid_d;
      resp_rdata_q      <= resp_rdata_d;
      resp_misaligned_q <= resp_misaligned_d;
      resp_error_q      <= resp_error_d;
    end
  end

  assign mem_address     = mem_address_q;
  assign mem_write_data  = mem_write_data_q;
  assign mem_write       = mem_write_q;
  assign mem_read        = mem_read_q;
  assign mem_size        = mem_size_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_misaligned_q;
  assign resp_error      = resp_error_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: SPLIT_MISALIGNED, default 1, 1 = split misaligned accesses into byte beats, 0 = reject them with resp_error.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  CPU request present.
REQ-005 req_ready  out  1  unit can accept a request (combinational: state==IDLE).
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-aligned.
REQ-009 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 resp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_misaligned  out  1  access was split (valid with resp_valid).
REQ-014 resp_error  out  1  illegal size or rejected misalignment (valid with resp_valid).
REQ-015 mem_address / mem_write_data  out  32 each  memory port address / store data.
REQ-016 mem_write / mem_read  out  1 each  memory port strobes.
REQ-017 mem_size  out  2  memory port access size, same encoding as req_size.
REQ-018 mem_read_data  in  32  memory read data, valid in the same cycle as mem_read.

Function
REQ-019 States SHALL be IDLE, ACCESS, RESP; a request SHALL be accepted at an edge where req_valid && req_ready, latching all req_* fields.
REQ-020 Aligned means: byte always; half when addr[0]==0; word when addr[1:0]==0.
REQ-021 Aligned access: ACCESS lasts 1 cycle driving mem_address=addr, mem_size=size, one strobe; resp_valid SHALL assert 2 cycles after the accept edge.
REQ-022 Misaligned access with SPLIT_MISALIGNED=1: ACCESS lasts N cycles (N=2 half, 4 word); beat i drives mem_address=addr+i (mod 2^32), mem_size=00, mem_write_data[7:0]=wdata[8i+7:8i]; resp_valid SHALL assert N+1 cycles after accept, with resp_misaligned=1.
REQ-023 Load beat i SHALL capture mem_read_data[7:0] into assembled bits [8i+7:8i] at the end of the beat; aligned loads SHALL capture mem_read_data whole.
REQ-024 Load result SHALL be extended by the unit from assembled bits [7:0] (byte) or [15:0] (half) per req_unsigned; word is passed unchanged; memory-side extension is ignored.
REQ-025 Size 11, or misaligned with SPLIT_MISALIGNED=0: no memory strobe; IDLE->RESP; resp_valid 1 cycle after accept with resp_error=1 and resp_rdata=0.
REQ-026 mem_read and mem_write SHALL never be high together and SHALL be 0 outside ACCESS.
REQ-027 RESP lasts exactly 1 cycle, then IDLE; a new request can be accepted the cycle after resp_valid.
REQ-028 req_valid outside IDLE SHALL be ignored; outside RESP, resp_valid=0 and resp_misaligned/resp_error=0.

Reset
REQ-029 rst_n low at an edge SHALL force IDLE; mem_write, mem_read, resp_valid, resp_misaligned and resp_error = 0; mem_address, mem_write_data, resp_rdata = 0; mem_size = 00.
REQ-030 Reset mid-ACCESS SHALL abandon the operation silently: no resp_valid and no further strobes, with req_ready=1 the cycle after reset is released.

Verification
REQ-031 Word store 0x12345678 at 0x0, then word load from 0x0 -> one mem_write beat with mem_size=10; load resp_rdata=0x12345678 at accept+2, resp_misaligned=0.
REQ-032 Word store 0xAABBCCDD at 0x21 -> byte writes DD, CC, BB, AA at 0x21..0x24; word load from 0x21 -> 0xAABBCCDD at accept+5, resp_misaligned=1.
REQ-033 Byte 0x80 at 0x40: signed load -> 0xFFFFFF80, unsigned load -> 0x00000080; half 0x8001 at 0x42, signed load -> 0xFFFF8001.
REQ-034 req_size=11 -> no strobe; resp_error=1, resp_rdata=0 at accept+1; SPLIT_MISALIGNED=0 with a half access at 0x3 -> same error response.
REQ-035 Half load at 0xFFFFFFFF -> byte reads at 0xFFFFFFFF, then 0x00000000; result assembled and sign-extended correctly.
REQ-036 rst_n low during beat 2 of a split word store -> strobes 0 next cycle, no resp_valid, req_ready=1 after release.
